reg_pipeline: RTL and testbench

REG_PIPELINE -- requirements
Module: reg_pipeline

---
 rtl/reg_pipeline_pkg.sv | 8 +
 rtl/reg_pipeline_stage.sv | 34 +++
 rtl/reg_pipeline.sv | 86 ++++++++
 tb/tb_reg_pipeline.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pipeline_pkg.sv
// reg_pipeline_pkg: shared defaults and occupancy width helper for reg_pipeline
package reg_pipeline_pkg;
  localparam int DEF_N = 8;
  localparam int DEF_DEPTH = 4;
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/reg_pipeline_stage.sv
// pipe_stage: one data register plus valid bit with load enable
module pipe_stage
  import reg_pipeline_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         d_valid,
  input  logic [N-1:0] d_data,
  output logic         q_valid,
  output logic [N-1:0] q_data
);
  logic         valid_d, valid_q;
  logic [N-1:0] data_d, data_q;
  // capture the source when loading, otherwise hold
  always_comb begin
    valid_d = load ? d_valid : valid_q;
    data_d  = load ? d_data : data_q;
  end
  // stage register, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign q_valid = valid_q;
  assign q_data  = data_q;
endmodule

// File: rtl/reg_pipeline.sv
// reg_pipeline: bubble-collapsing valid/ready register pipeline; optional flush via REG_PIPELINE_FLUSH_EN
module reg_pipeline
  import reg_pipeline_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          in_valid,
  input  logic [N-1:0]                  in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [N-1:0]                  out_data,
  input  logic                          out_ready,
`ifdef REG_PIPELINE_FLUSH_EN
  input  logic                          flush,
`endif
  output logic [occ_width(DEPTH)-1:0]   occupancy
);
  localparam int OW = occ_width(DEPTH);
  logic [DEPTH-1:0] v, adv;
  logic [N-1:0]     data [DEPTH];
  logic [OW-1:0]    occ_d, occ_q;
  logic             in_xfer, out_xfer;
  // a stage may advance if it holds a bubble or everything downstream moves
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = !v[DEPTH-1] || out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) adv[k] = !v[k] || adv[k+1];
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic         src_v, st_v, st_ld;
    logic [N-1:0] src_d, st_d;
    if (i == 0) begin : g_head
      assign src_v = in_valid;
      assign src_d = in_data;
    end else begin : g_body
      assign src_v = v[i-1];
      assign src_d = data[i-1];
    end
`ifdef REG_PIPELINE_FLUSH_EN
    assign st_ld = en && (adv[i] || flush);
    assign st_v  = src_v && !flush;
    assign st_d  = flush ? data[i] : src_d;
`else
    assign st_ld = en && adv[i];
    assign st_v  = src_v;
    assign st_d  = src_d;
`endif
    pipe_stage #(.N(N)) u_stage (
      .clk    (clk),
      .reset  (reset),
      .load   (st_ld),
      .d_valid(st_v),
      .d_data (st_d),
      .q_valid(v[i]),
      .q_data (data[i])
    );
  end
`ifdef REG_PIPELINE_FLUSH_EN
  assign in_ready  = reset && en && adv[0] && !flush;
  assign out_valid = en && v[DEPTH-1] && !flush;
`else
  assign in_ready  = reset && en && adv[0];
  assign out_valid = en && v[DEPTH-1];
`endif
  assign out_data  = data[DEPTH-1];
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  // track valid-stage count from the handshakes
  always_comb begin
`ifdef REG_PIPELINE_FLUSH_EN
    occ_d = (flush && en) ? '0 : occ_q + OW'(in_xfer) - OW'(out_xfer);
`else
    occ_d = occ_q + OW'(in_xfer) - OW'(out_xfer);
`endif
  end
  // occupancy register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) occ_q <= '0;
    else occ_q <= occ_d;
  end
  assign occupancy = occ_q;
endmodule

// File: tb/tb_reg_pipeline.sv
// tb_reg_pipeline: table-driven and directed checks for reg_pipeline (N=8, DEPTH=4)
module tb_reg_pipeline;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b1;
  logic [2:0] occupancy;
`ifdef REG_PIPELINE_FLUSH_EN
  logic       flush = 1'b0;
`endif
  int checks = 0;
  int errors = 0;

  reg_pipeline #(.N(8), .DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
`ifdef REG_PIPELINE_FLUSH_EN
    .flush    (flush),
`endif
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en, iv;
    logic [7:0] d;
    logic       ordy, e_ir, e_ov;
    logic [7:0] e_od;
    logic [2:0] e_occ;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(input int e, input int iv, input int d, input int o,
                              input int ir, input int ov, input int od, input int occ);
    vec_t r;
    r.en = e[0]; r.iv = iv[0]; r.d = d[7:0]; r.ordy = o[0];
    r.e_ir = ir[0]; r.e_ov = ov[0]; r.e_od = od[7:0]; r.e_occ = occ[2:0];
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data = d;
    #1;
    chk("push_ready", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int base, input int count);
    int n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && n < count; c++) begin
      #1;
      if (out_valid) begin
        chk(name, int'(out_data), base + n);
        n++;
      end
      step();
    end
    chk({name, "_count"}, n, count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int nin, nout;
    tbl[0]  = mk(1, 1, 'h33, 1, 1, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 1, 1, 0, 0, 1);
    tbl[2]  = mk(1, 0, 0, 1, 1, 0, 0, 1);
    tbl[3]  = mk(1, 0, 0, 1, 1, 0, 0, 1);
    tbl[4]  = mk(1, 0, 0, 1, 1, 1, 'h33, 1);
    tbl[5]  = mk(1, 1, 'hA1, 1, 1, 0, 0, 0);
    tbl[6]  = mk(1, 1, 'hA2, 1, 1, 0, 0, 1);
    tbl[7]  = mk(1, 1, 'hA3, 1, 1, 0, 0, 2);
    tbl[8]  = mk(1, 1, 'hA4, 1, 1, 0, 0, 3);
    tbl[9]  = mk(1, 1, 'hA5, 1, 1, 1, 'hA1, 4);
    tbl[10] = mk(1, 0, 0, 1, 1, 1, 'hA2, 4);
    tbl[11] = mk(1, 0, 0, 0, 1, 1, 'hA3, 3);
    tbl[12] = mk(1, 1, 'hA6, 0, 1, 1, 'hA3, 3);
    tbl[13] = mk(1, 1, 'hA7, 0, 0, 1, 'hA3, 4);
    tbl[14] = mk(0, 1, 'hA7, 1, 0, 0, 0, 4);
    tbl[15] = mk(1, 1, 'hA7, 1, 1, 1, 'hA3, 4);
    tbl[16] = mk(1, 0, 0, 1, 1, 1, 'hA4, 4);
    tbl[17] = mk(1, 0, 0, 1, 1, 1, 'hA5, 3);
    tbl[18] = mk(1, 0, 0, 1, 1, 1, 'hA6, 2);
    tbl[19] = mk(1, 0, 0, 1, 1, 1, 'hA7, 1);
    tbl[20] = mk(1, 0, 0, 1, 1, 0, 0, 0);

    reset = 1'b0; en = 1'b1; in_valid = 1'b1; in_data = 8'h0F; out_ready = 1'b1;
    repeat (3) step();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_occupancy", int'(occupancy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    step();

    for (int i = 0; i < 21; i++) begin
      en = tbl[i].en; in_valid = tbl[i].iv; in_data = tbl[i].d; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), int'(in_ready), int'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_out_valid", i), int'(out_valid), int'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_occupancy", i), int'(occupancy), int'(tbl[i].e_occ));
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_data", i), int'(out_data), int'(tbl[i].e_od));
      step();
    end

    en = 1'b1; out_ready = 1'b0; nin = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; in_data = 8'(nin + 1);
      #1;
      if (in_ready) nin++;
      step();
    end
    chk("bp_accepted", nin, 4);
    in_valid = 1'b1; in_data = 8'(nin + 1);
    #1;
    chk("bp_in_ready", int'(in_ready), 0);
    chk("bp_occupancy", int'(occupancy), 4);
    out_ready = 1'b1; nout = 0;
    for (int c = 0; c < 40 && nout < 6; c++) begin
      in_valid = (nin < 6); in_data = 8'(nin + 1);
      #1;
      if (out_valid) begin
        chk("bp_order", int'(out_data), nout + 1);
        nout++;
      end
      if (in_valid && in_ready) nin++;
      step();
    end
    chk("bp_count", nout, 6);
    in_valid = 1'b0;
    step();

    push(8'h11); push(8'h12); push(8'h13);
    en = 1'b0; in_valid = 1'b1; in_data = 8'h99;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("frz_in_ready", int'(in_ready), 0);
      chk("frz_out_valid", int'(out_valid), 0);
      chk("frz_occupancy", int'(occupancy), 3);
      step();
    end
    en = 1'b1;
    drain("frz_order", 'h11, 3);

    push(8'h21); push(8'h22); push(8'h23);
    #1;
    chk("mid_occ_before", int'(occupancy), 3);
    #1 reset = 1'b0;
    #1;
    chk("mid_out_valid", int'(out_valid), 0);
    chk("mid_occupancy", int'(occupancy), 0);
    chk("mid_in_ready", int'(in_ready), 0);
    #1 reset = 1'b1;
    step();
    push(8'hF0);
    step();
    chk("lat_early1", int'(out_valid), 0);
    step();
    chk("lat_early2", int'(out_valid), 0);
    step();
    chk("lat_out_valid", int'(out_valid), 1);
    chk("lat_out_data", int'(out_data), 'hF0);
    chk("lat_occ", int'(occupancy), 1);
    step();
    chk("lat_occ_after", int'(occupancy), 0);

`ifdef REG_PIPELINE_FLUSH_EN
    out_ready = 1'b0;
    push(8'h41); push(8'h42); push(8'h43); push(8'h44);
    #1;
    chk("fl_occ_full", int'(occupancy), 4);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    #1;
    chk("fl_in_ready", int'(in_ready), 0);
    chk("fl_out_valid", int'(out_valid), 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("fl_occupancy", int'(occupancy), 0);
    chk("fl_out_valid_after", int'(out_valid), 0);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
